// File: rtl/key_filter_pkg.sv
// Shared definitions for the key filter: per-channel FSM state codes and a width helper.
package key_filter_pkg;

  typedef logic [1:0] chan_state_t;

  // PRESSED and RELEASE_WAIT share bit 1 so the debounced level is just state[1]
  localparam chan_state_t ST_IDLE         = 2'd0;
  localparam chan_state_t ST_PRESS_WAIT   = 2'd1;
  localparam chan_state_t ST_PRESSED      = 2'd2;
  localparam chan_state_t ST_RELEASE_WAIT = 2'd3;

  function automatic int clog2_width(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM and auto-repeat timer.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = clog2_width(DEBOUNCE_CYCLES);
  localparam int HW = clog2_width(REPEAT_DELAY + 1);
  localparam int PW = clog2_width(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_FIRE = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(REPEAT_DELAY);
  localparam logic [PW-1:0] PER_LAST  = PW'(REPEAT_PERIOD - 1);
  localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);
  localparam logic REP_ON       = (REPEAT_EN != 0);

  logic [1:0]    sync;
  logic          sample;
  chan_state_t   state;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hold;
  logic [PW-1:0] per;
  logic          press_done;
  logic          release_done;
  logic          held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= {2{RELEASED_RAW}};
    else      sync <= {sync[0], key_n};
  end

  // XOR with the released level normalises the sample to 1 = pressed
  assign sample       = sync[1] ^ RELEASED_RAW;
  assign key_state    = state[1];
  assign press_done   = (state == ST_PRESS_WAIT) && sample && (cnt == CNT_LAST);
  assign release_done = (state == ST_RELEASE_WAIT) && !sample && (cnt == CNT_LAST);
  assign held         = key_state && !release_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_done;
      release_pulse <= release_done;
      case (state)
        ST_IDLE:
          if (sample) begin
            state <= ST_PRESS_WAIT;
            cnt   <= '0;
          end
        ST_PRESS_WAIT:
          if (!sample)         state <= ST_IDLE;
          else if (press_done) state <= ST_PRESSED;
          else                 cnt   <= cnt + 1'b1;
        ST_PRESSED:
          if (!sample) begin
            state <= ST_RELEASE_WAIT;
            cnt   <= '0;
          end
        ST_RELEASE_WAIT:
          if (sample)            state <= ST_PRESSED;
          else if (release_done) state <= ST_IDLE;
          else                   cnt   <= cnt + 1'b1;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hold timer saturates after the first repeat; the period counter takes over from there
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold         <= '0;
      per          <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (press_done) begin
        hold <= '0;
        per  <= '0;
      end else if (held) begin
        if (hold < HOLD_FIRE) begin
          hold <= hold + 1'b1;
        end else if (hold == HOLD_FIRE) begin
          hold         <= HOLD_SAT;
          per          <= '0;
          repeat_pulse <= REP_ON;
        end else if (per == PER_LAST) begin
          per          <= '0;
          repeat_pulse <= REP_ON;
        end else begin
          per <= per + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/key_filter.sv
// Multi-channel key debouncer with press/release/auto-repeat pulses; one channel block per key.
module key_filter #(
  parameter int N               = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_n,
  output logic [N-1:0] key_state,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] repeat_pulse
);

  for (genvar i = 0; i < N; i++) begin : g_chan
    key_filter_chan #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_EN       (REPEAT_EN),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .key_n         (key_n[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: debounce latency, bounce rejection, repeat timing and reset abort.
module tb_key_filter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_n;
  logic [N-1:0] key_state;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] repeat_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  key_filter #(
    .N               (N),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_n         (key_n),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int ch, input logic level);
    key_n[ch] = level;
  endtask

  // Press a key and expect exactly one press pulse on edge 7 with key_state rising with it
  task automatic pressKey(input int ch);
    applyStimulus(ch, 1'b0);
    for (int e = 1; e <= 7; e++) begin
      tick();
      checkOutput($sformatf("press ch%0d e%0d", ch, e), 32'(press_pulse[ch]), 32'(e == 7));
      checkOutput($sformatf("state ch%0d e%0d", ch, e), 32'(key_state[ch]), 32'(e == 7));
    end
  endtask

  initial begin
    rst   = 1'b0;
    key_n = '1;
    #3;
    checkOutput("reset key_state", 32'(key_state), 32'h0);
    checkOutput("reset press", 32'(press_pulse), 32'h0);
    checkOutput("reset release", 32'(release_pulse), 32'h0);
    checkOutput("reset repeat", 32'(repeat_pulse), 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();

    // Clean press on channel 0, followed by one idle edge
    pressKey(0);
    tick();
    checkOutput("press ch0 after", 32'(press_pulse[0]), 32'h0);
    checkOutput("state ch0 held", 32'(key_state[0]), 32'h1);

    // Bounce on channel 1 every 2 cycles must never be accepted
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, ((c / 2) % 2) != 0);
      tick();
      checkOutput($sformatf("bounce press c%0d", c), 32'(press_pulse[1]), 32'h0);
      checkOutput($sformatf("bounce state c%0d", c), 32'(key_state[1]), 32'h0);
    end
    applyStimulus(1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      tick();
      checkOutput($sformatf("bounce tail press c%0d", c), 32'(press_pulse[1]), 32'h0);
      checkOutput($sformatf("bounce tail release c%0d", c), 32'(release_pulse[1]), 32'h0);
      checkOutput($sformatf("bounce tail state c%0d", c), 32'(key_state[1]), 32'h0);
    end

    // Hold channel 2: repeats at press+10 then every 3 cycles
    pressKey(2);
    for (int k = 1; k <= 30; k++) begin
      tick();
      checkOutput($sformatf("repeat ch2 +%0d", k), 32'(repeat_pulse[2]),
                  32'((k >= 10) && (k <= 28) && ((k - 10) % 3 == 0)));
      checkOutput($sformatf("press ch2 +%0d", k), 32'(press_pulse[2]), 32'h0);
    end
    applyStimulus(2, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkOutput($sformatf("release ch2 e%0d", e), 32'(release_pulse[2]), 32'(e == 7));
      checkOutput($sformatf("state ch2 rel e%0d", e), 32'(key_state[2]), 32'(e < 7));
    end

    // Simultaneous release of channels 0 and 3
    pressKey(3);
    applyStimulus(0, 1'b1);
    applyStimulus(3, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkOutput($sformatf("release 0+3 e%0d", e), 32'(release_pulse & 4'b1001),
                  (e == 7) ? 32'h9 : 32'h0);
      checkOutput($sformatf("state 0+3 e%0d", e), 32'(key_state & 4'b1001),
                  (e < 7) ? 32'h9 : 32'h0);
    end

    // Reset while channel 0 debounces and channel 2 is held, keys kept down through reset
    pressKey(2);
    applyStimulus(0, 1'b0);
    for (int e = 1; e <= 4; e++) tick();
    checkOutput("mid debounce state", 32'(key_state), 32'h4);
    checkOutput("mid debounce press", 32'(press_pulse), 32'h0);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst async state", 32'(key_state), 32'h0);
    checkOutput("rst async press", 32'(press_pulse), 32'h0);
    checkOutput("rst async release", 32'(release_pulse), 32'h0);
    checkOutput("rst async repeat", 32'(repeat_pulse), 32'h0);
    tick();
    tick();
    checkOutput("rst held state", 32'(key_state), 32'h0);
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checkOutput($sformatf("post rst press e%0d", e), 32'(press_pulse), (e == 7) ? 32'h5 : 32'h0);
      checkOutput($sformatf("post rst release e%0d", e), 32'(release_pulse), 32'h0);
      checkOutput($sformatf("post rst state e%0d", e), 32'(key_state), (e >= 7) ? 32'h5 : 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter N, default 4: number of independent key channels (1..32).
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means key_n bit = 0 is pressed; 0 means bit = 1 is pressed.
REQ-003 Parameter DEBOUNCE_CYCLES, default 2_000_000: consecutive stable samples needed to accept a change (20 ms at 100 MHz); minimum 2.
REQ-004 Parameter REPEAT_EN, default 0: 1 enables auto-repeat pulses while a key is held.
REQ-005 Parameter REPEAT_DELAY, default 50_000_000: held cycles after press_pulse before the first repeat_pulse.
REQ-006 Parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent repeat_pulse events.
REQ-007 clk  in  1  single system clock; all logic on rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 key_n  in  N  raw asynchronous key inputs, polarity per ACTIVE_LOW.
REQ-010 key_state  out  N  debounced level per channel; 1 = pressed.
REQ-011 press_pulse  out  N  one-cycle high per accepted press.
REQ-012 release_pulse  out  N  one-cycle high per accepted release.
REQ-013 repeat_pulse  out  N  one-cycle high per auto-repeat event; constant 0 when REPEAT_EN = 0.

Function
REQ-014 Each key_n bit SHALL pass through a 2-flop synchroniser, then be normalised so that 1 = pressed, giving sample s.
REQ-015 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT and one debounce counter of width clog2(DEBOUNCE_CYCLES).
REQ-016 IDLE: s = 1 → PRESS_WAIT with cnt = 0.
REQ-017 PRESS_WAIT: s = 0 → IDLE, no pulse; s = 1 with cnt = DEBOUNCE_CYCLES-1 → PRESSED and press_pulse asserted; otherwise cnt increments.
REQ-018 PRESSED: s = 0 → RELEASE_WAIT with cnt = 0.
REQ-019 RELEASE_WAIT: s = 1 → PRESSED, no pulse, repeat timing preserved; s = 0 with cnt = DEBOUNCE_CYCLES-1 → IDLE and release_pulse asserted; otherwise cnt increments.
REQ-020 key_state SHALL be 1 in PRESSED and RELEASE_WAIT, and 0 otherwise; it changes in the same cycle as the corresponding pulse.
REQ-021 Latency: with a clean input step held stable, the pulse SHALL go high on clock edge DEBOUNCE_CYCLES+3 after the step, counting the first edge that samples the new level as edge 1.
REQ-022 Any bounce during a WAIT state SHALL discard the partial count; no pulse is produced for a glitch shorter than DEBOUNCE_CYCLES.
REQ-023 Repeat behaviour:
- A hold counter SHALL clear on entry to PRESSED from PRESS_WAIT.
- repeat_pulse SHALL fire after REPEAT_DELAY held cycles, then every REPEAT_PERIOD cycles, while in PRESSED or RELEASE_WAIT.
- The hold counter SHALL saturate rather than wrap.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
REQ-025 press_pulse, release_pulse and repeat_pulse SHALL never be high for more than one consecutive cycle on a channel, and press and release SHALL never be high together on a channel.

Reset
REQ-026 On rst = 0, all outputs SHALL be 0 immediately, all FSMs SHALL go to IDLE, counters to 0, and synchroniser flops to the released level.
REQ-027 Reset mid-debounce or mid-hold SHALL abort without producing a pulse; a key held through reset release SHALL produce press_pulse after the normal latency.

Structure
REQ-028 Shared package key_filter_pkg SHALL hold the channel state enum and a clog2 width helper.
REQ-029 Per-channel logic SHALL be sub-module key_filter_chan, containing the synchroniser, FSM and counters; the top SHALL instantiate it N times via generate.

Verification
All scenarios use N = 4, DEBOUNCE_CYCLES = 4, REPEAT_EN = 1, REPEAT_DELAY = 10, REPEAT_PERIOD = 3, ACTIVE_LOW = 1.
REQ-030 Clean press: key_n[0] goes 1 → 0 and is held → press_pulse[0] high for exactly one cycle at edge 7; key_state[0] goes to 1 in the same cycle.
REQ-031 Bounce: key_n[1] toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → no pulses, key_state[1] stays 0.
REQ-032 Hold and repeat: key_n[2] held low for 30 cycles after press_pulse → repeat_pulse[2] at press+10, +13, +16, +19, +22, +25, +28.
REQ-033 Release and simultaneous events: key_n[0] and key_n[3] released on the same edge → release_pulse[0] and release_pulse[3] high together 7 edges later, and both key_state bits go to 0.
REQ-034 Reset mid-debounce: rst pulsed low during PRESS_WAIT on channel 0 → outputs 0 at once; with the key still held, press_pulse[0] appears 7 edges after rst is released.
